// File: rtl/barrel_pkg.sv
// barrel_pkg: shared width default, rotate helpers and stage payload type for the barrel shifter pair
package barrel_pkg;
  localparam int BARREL_W = 4;
  localparam int BARREL_MAXW = 64;
  typedef struct packed {
    logic [BARREL_W-1:0] data;
    logic [$clog2(BARREL_W)-1:0] amt;
    logic par;
  } payload_t;
  function automatic logic [BARREL_MAXW-1:0] rotl(input logic [BARREL_MAXW-1:0] data, input int amt, input int w);
    logic [BARREL_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[(i + amt) % w] = data[i];
    return r;
  endfunction
  function automatic logic [BARREL_MAXW-1:0] rotr(input logic [BARREL_MAXW-1:0] data, input int amt, input int w);
    logic [BARREL_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[(i + w - (amt % w)) % w] = data[i];
    return r;
  endfunction
endpackage

// File: rtl/barrel_unrotator_stage.sv
// unrot_stage: one registered conditional rotate-left by 2^K with valid/ready advance; parity port under BARREL_UNROT_PARITY_EN
module unrot_stage
  import barrel_pkg::*;
#(
  parameter int W = BARREL_W,
  parameter int K = 0,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
`ifdef BARREL_UNROT_PARITY_EN
  input  logic          in_par,
  output logic          out_par,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_amt
);
  localparam int S = 1 << K;
  logic [W-1:0] rot;
  // in_amt[0] is always this stage's bit: earlier stages shift the consumed bits out
  assign rot = in_amt[0] ? {in_data[W-1-S:0], in_data[W-1:W-S]} : in_data;
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_amt <= '0;
`ifdef BARREL_UNROT_PARITY_EN
      out_par <= 1'b0;
`endif
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= rot;
        out_amt <= in_amt >> 1;
`ifdef BARREL_UNROT_PARITY_EN
        out_par <= in_par;
`endif
      end
    end
  end
endmodule

// File: rtl/barrel_unrotator.sv
// barrel_unrotator: pipelined rotate-left by in_amt undoing the forward rotate-right, one stage per amount bit
// ports: clk, rst (sync, active-high), in_valid/in_ready/in_data/in_amt, out_valid/out_ready/out_data
// BARREL_UNROT_PARITY_EN adds in_par (even parity of the unrotated word) and out_par_err
module barrel_unrotator
  import barrel_pkg::*;
#(
  parameter int W = BARREL_W,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
`ifdef BARREL_UNROT_PARITY_EN
  input  logic          in_par,
  output logic          out_par_err,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data
);
  logic [SW:0] v, rdy;
  logic [W-1:0] d [SW+1];
  logic [SW-1:0] a [SW+1];
  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign a[0] = in_amt;
  assign in_ready = rdy[0];
  assign rdy[SW] = out_ready;
  assign out_valid = v[SW];
  assign out_data = d[SW];
`ifdef BARREL_UNROT_PARITY_EN
  logic [SW:0] p;
  assign p[0] = in_par;
  assign out_par_err = out_valid && ((^out_data) != p[SW]);
`endif
  for (genvar k = 0; k < SW; k++) begin : g_stage
    unrot_stage #(.W(W), .K(k)) u_stage (
      .clk(clk),
      .rst(rst),
      .in_valid(v[k]),
      .in_ready(rdy[k]),
      .in_data(d[k]),
      .in_amt(a[k]),
`ifdef BARREL_UNROT_PARITY_EN
      .in_par(p[k]),
      .out_par(p[k+1]),
`endif
      .out_valid(v[k+1]),
      .out_ready(rdy[k+1]),
      .out_data(d[k+1]),
      .out_amt(a[k+1])
    );
  end
endmodule

// File: tb/tb_barrel_unrotator.sv
// tb_barrel_unrotator: directed self-checking bench for barrel_unrotator at the default width
module tb_barrel_unrotator;
  import barrel_pkg::*;
  localparam int W = BARREL_W;
  localparam int SW = $clog2(W);
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] in_data = '0, out_data;
  logic [SW-1:0] in_amt = '0;
`ifdef BARREL_UNROT_PARITY_EN
  logic in_par = 1'b0, out_par_err;
`endif
  int tests = 0, fails = 0;
  int first, last, nout, idx, start;
  logic [63:0] t;
  logic [W-1:0] q[$], got[$];
  logic [3:0] t1_exp [4] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101};
  logic [3:0] t4_in [4] = '{4'h8, 4'h3, 4'h5, 4'hC};
  logic [1:0] t4_amt [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
  logic [3:0] t4_exp [4] = '{4'h4, 4'hC, 4'hA, 4'hC};
  barrel_unrotator #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_amt(in_amt),
`ifdef BARREL_UNROT_PARITY_EN
    .in_par(in_par),
    .out_par_err(out_par_err),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 4'b1011;
      in_amt = SW'(a);
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_not_early", 32'(out_valid), 0);
      @(negedge clk);
      check("t1_valid", 32'(out_valid), 1);
      check("t1_data", 32'(out_data), 32'(t1_exp[a]));
    end
    first = -1;
    last = -1;
    nout = 0;
    for (int c = 0; c < 68; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        nout++;
        if (q.size() == 0) check("t2_extra", 32'(out_valid), 0);
        else check("t2_data", 32'(out_data), 32'(q.pop_front()));
      end
      if (c < 64) begin
        t = rotr(64'(c % 16), c / 16, W);
        in_valid = 1'b1;
        in_data = t[W-1:0];
        in_amt = SW'(c / 16);
        q.push_back(W'(c % 16));
      end else in_valid = 1'b0;
    end
    check("t2_count", 32'(nout), 64);
    check("t2_first", 32'(first), 2);
    check("t2_last", 32'(last), 65);
    in_amt = 1;
    idx = 0;
    start = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid && start < 0) start = c;
      out_ready = (start >= 0 && c < start + 3) ? 1'b0 : 1'b1;
      in_valid = idx < 4;
      in_data = W'(idx + 1);
      #1;
      if (start >= 0 && c < start + 3) begin
        check("t3_hold", 32'(out_data), 32'h2);
        check("t3_in_ready", 32'(in_ready), 0);
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t3_count", 32'(got.size()), 4);
    for (int i = 0; i < 4; i++) check("t3_out", i < got.size() ? 32'(got[i]) : 32'hDEAD, 32'(2 * (i + 1)));
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check("t4_valid", 32'(out_valid), 32'(c >= 2 && c <= 8 && c % 2 == 0));
      if (out_valid) check("t4_data", 32'(out_data), 32'(t4_exp[((c - 2) / 2) % 4]));
      in_valid = (c % 2 == 0) && (c < 8);
      in_data = t4_in[(c / 2) % 4];
      in_amt = t4_amt[(c / 2) % 4];
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 4'h6;
    in_amt = 0;
    @(negedge clk);
    in_data = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_valid_clr", 32'(out_valid), 0);
    check("t5_data_clr", 32'(out_data), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_out", 32'(out_valid), 0);
    end
`ifdef BARREL_UNROT_PARITY_EN
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 4'b0111;
    in_amt = 1;
    in_par = 1'b1;
    @(negedge clk);
    in_par = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_valid", 32'(out_valid), 1);
    check("t6_data", 32'(out_data), 32'hE);
    check("t6_par_ok", 32'(out_par_err), 0);
    @(negedge clk);
    check("t6_data2", 32'(out_data), 32'hE);
    check("t6_par_err", 32'(out_par_err), 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
